// File: rtl/cplx_butterfly_pipe_pkg.sv
// Shared fixed-point complex definitions used by the butterfly pipeline and
// later twiddle-rotation blocks: default Q(I,F) widths, the complex sample
// type, pipeline depth and the saturating narrow helper used when
// CPLX_BUTTERFLY_SAT_EN is defined.
package cplx_butterfly_pipe_pkg;

  localparam int unsigned FXP_I      = 2;
  localparam int unsigned FXP_F      = 14;
  localparam int unsigned FXP_W      = FXP_I + FXP_F;
  localparam int unsigned PIPE_DEPTH = 3;

  // Complex sample at the default component width.
  typedef struct packed {
    logic signed [FXP_W-1:0] re;
    logic signed [FXP_W-1:0] im;
  } cplx_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  // The caller keeps the low w bits of the result.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cplx_butterfly_pipe_if.sv
// Valid/ready bus of the butterfly pipeline: upstream operand/twiddle side
// and downstream result side. The slave modport is the butterfly's view.
interface cplx_butterfly_pipe_if #(
  parameter int unsigned I     = 2,
  parameter int unsigned F     = 14,
  parameter int unsigned TAG_W = 10
);
  localparam int unsigned W = I + F;

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a_re;
  logic signed [W-1:0] a_im;
  logic signed [W-1:0] b_re;
  logic signed [W-1:0] b_im;
  logic signed [W-1:0] w_re;
  logic signed [W-1:0] w_im;
  logic                sc;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_re;
  logic signed [W-1:0] x_im;
  logic signed [W-1:0] y_re;
  logic signed [W-1:0] y_im;
  logic [TAG_W-1:0]    out_tag;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, sc, in_tag, out_ready,
    output in_ready, out_valid, x_re, x_im, y_re, y_im, out_tag
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, sc, in_tag, out_ready,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im, out_tag
  );

endinterface

// File: rtl/cplx_butterfly_pipe_mul.sv
// cplx_mul_pipe: one registered complex multiply t = w*b in Q(I,F).
// Products are formed at 2W bits, combined at 2W+1 bits, shifted right by F
// (floor) and narrowed to W bits: wrap by default, saturate when
// CPLX_BUTTERFLY_SAT_EN is defined. The output register advances only on en.
module cplx_mul_pipe
  import cplx_butterfly_pipe_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned F = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic signed [W-1:0] w_re,
  input  logic signed [W-1:0] w_im,
  output logic signed [W-1:0] t_re,
  output logic signed [W-1:0] t_im
);
  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] p_rr_s;
  logic signed [PW-1:0] p_ii_s;
  logic signed [PW-1:0] p_ri_s;
  logic signed [PW-1:0] p_ir_s;
  logic signed [PW:0]   s_re_s;
  logic signed [PW:0]   s_im_s;

  // Shift the 2W+1-bit sum down by F and bring it back to W bits.
  function automatic logic signed [W-1:0] narrow_prod(input logic signed [PW:0] v);
    logic signed [PW:0] sh;
`ifdef CPLX_BUTTERFLY_SAT_EN
    logic signed [63:0] ext;
    logic signed [63:0] lim;
`endif
    sh = v >>> F;
`ifdef CPLX_BUTTERFLY_SAT_EN
    ext = {{(63 - PW){sh[PW]}}, sh};
    lim = sat_narrow(ext, W);
    return lim[W-1:0];
`else
    return sh[W-1:0];
`endif
  endfunction

  // Four full-width signed products and their real/imaginary combinations.
  always_comb begin
    p_rr_s = $signed({{W{w_re[W-1]}}, w_re}) * $signed({{W{b_re[W-1]}}, b_re});
    p_ii_s = $signed({{W{w_im[W-1]}}, w_im}) * $signed({{W{b_im[W-1]}}, b_im});
    p_ri_s = $signed({{W{w_re[W-1]}}, w_re}) * $signed({{W{b_im[W-1]}}, b_im});
    p_ir_s = $signed({{W{w_im[W-1]}}, w_im}) * $signed({{W{b_re[W-1]}}, b_re});
    s_re_s = $signed({p_rr_s[PW-1], p_rr_s}) - $signed({p_ii_s[PW-1], p_ii_s});
    s_im_s = $signed({p_ri_s[PW-1], p_ri_s}) + $signed({p_ir_s[PW-1], p_ir_s});
  end

  // Product register; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_re <= '0;
      t_im <= '0;
    end else if (en) begin
      t_re <= narrow_prod(s_re_s);
      t_im <= narrow_prod(s_im_s);
    end
  end

endmodule

// File: rtl/cplx_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: x = (a + w*b) >> sc, y = (a - w*b) >> sc.
// S1 registers the inputs, S2 (cplx_mul_pipe) forms t = w*b, S3 forms and
// holds x/y. One global enable stalls every stage together; bubbles stay.
// Optional: CPLX_BUTTERFLY_SAT_EN saturates every narrowing instead of wrapping.
module cplx_butterfly_pipe
  import cplx_butterfly_pipe_pkg::*;
#(
  parameter int unsigned I     = FXP_I,
  parameter int unsigned F     = FXP_F,
  parameter int unsigned TAG_W = 10
) (
  input logic                 clk,
  input logic                 rst,
  cplx_butterfly_pipe_if.slave bus
);
  localparam int unsigned W = I + F;

  logic                adv_s;
  // S1
  logic                v1_r;
  logic signed [W-1:0] a1_re_r, a1_im_r, b1_re_r, b1_im_r, w1_re_r, w1_im_r;
  logic                sc1_r;
  logic [TAG_W-1:0]    tag1_r;
  // S2
  logic                v2_r;
  logic signed [W-1:0] a2_re_r, a2_im_r;
  logic signed [W-1:0] t_re_s, t_im_s;
  logic                sc2_r;
  logic [TAG_W-1:0]    tag2_r;
  // S3
  logic                v3_r;
  logic signed [W-1:0] x_re_r, x_im_r, y_re_r, y_im_r;
  logic [TAG_W-1:0]    tag3_r;
  logic signed [W:0]   xs_re_s, xs_im_s, ys_re_s, ys_im_s;

  // Shift a W+1-bit sum by the transaction's scale bit and narrow to W bits.
  function automatic logic signed [W-1:0] narrow_out(input logic signed [W:0] v,
                                                     input logic s);
    logic signed [W:0] sh;
`ifdef CPLX_BUTTERFLY_SAT_EN
    logic signed [63:0] ext;
    logic signed [63:0] lim;
`endif
    sh = v >>> s;
`ifdef CPLX_BUTTERFLY_SAT_EN
    ext = {{(63 - W){sh[W]}}, sh};
    lim = sat_narrow(ext, W);
    return lim[W-1:0];
`else
    return sh[W-1:0];
`endif
  endfunction

  // Whole pipe advances unless a result is waiting and downstream refuses it.
  always_comb begin
    adv_s = !v3_r || bus.out_ready;
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = v3_r;
  assign bus.x_re      = x_re_r;
  assign bus.x_im      = x_im_r;
  assign bus.y_re      = y_re_r;
  assign bus.y_im      = y_im_r;
  assign bus.out_tag   = tag3_r;

  // S1: capture the offered transaction (or a bubble) on every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      a1_re_r <= '0;
      a1_im_r <= '0;
      b1_re_r <= '0;
      b1_im_r <= '0;
      w1_re_r <= '0;
      w1_im_r <= '0;
      sc1_r   <= 1'b0;
      tag1_r  <= '0;
    end else if (adv_s) begin
      v1_r    <= bus.in_valid;
      a1_re_r <= bus.a_re;
      a1_im_r <= bus.a_im;
      b1_re_r <= bus.b_re;
      b1_im_r <= bus.b_im;
      w1_re_r <= bus.w_re;
      w1_im_r <= bus.w_im;
      sc1_r   <= bus.sc;
      tag1_r  <= bus.in_tag;
    end
  end

  cplx_mul_pipe #(
    .W (W),
    .F (F)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .en   (adv_s),
    .b_re (b1_re_r),
    .b_im (b1_im_r),
    .w_re (w1_re_r),
    .w_im (w1_im_r),
    .t_re (t_re_s),
    .t_im (t_im_s)
  );

  // S2: carry a, sc and tag alongside the product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      a2_re_r <= '0;
      a2_im_r <= '0;
      sc2_r   <= 1'b0;
      tag2_r  <= '0;
    end else if (adv_s) begin
      v2_r    <= v1_r;
      a2_re_r <= a1_re_r;
      a2_im_r <= a1_im_r;
      sc2_r   <= sc1_r;
      tag2_r  <= tag1_r;
    end
  end

  // Butterfly sum/difference at W+1 bits so the carry is never lost.
  always_comb begin
    xs_re_s = $signed({a2_re_r[W-1], a2_re_r}) + $signed({t_re_s[W-1], t_re_s});
    xs_im_s = $signed({a2_im_r[W-1], a2_im_r}) + $signed({t_im_s[W-1], t_im_s});
    ys_re_s = $signed({a2_re_r[W-1], a2_re_r}) - $signed({t_re_s[W-1], t_re_s});
    ys_im_s = $signed({a2_im_r[W-1], a2_im_r}) - $signed({t_im_s[W-1], t_im_s});
  end

  // S3: output register, held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r   <= 1'b0;
      x_re_r <= '0;
      x_im_r <= '0;
      y_re_r <= '0;
      y_im_r <= '0;
      tag3_r <= '0;
    end else if (adv_s) begin
      v3_r   <= v2_r;
      x_re_r <= narrow_out(xs_re_s, sc2_r);
      x_im_r <= narrow_out(xs_im_s, sc2_r);
      y_re_r <= narrow_out(ys_re_s, sc2_r);
      y_im_r <= narrow_out(ys_im_s, sc2_r);
      tag3_r <= tag2_r;
    end
  end

endmodule

// File: tb/tb_cplx_butterfly_pipe.sv
// Self-checking bench for cplx_butterfly_pipe (I=2, F=14, TAG_W=10).
// Reference: plain integer butterfly arithmetic plus an in-order expectation
// queue; honours CPLX_BUTTERFLY_SAT_EN the same way the design build does.
module tb_cplx_butterfly_pipe;
  import cplx_butterfly_pipe_pkg::*;

  localparam int unsigned I     = 2;
  localparam int unsigned F     = 14;
  localparam int unsigned TAG_W = 10;
  localparam int unsigned W     = I + F;

  typedef struct {
    cplx_t            x;
    cplx_t            y;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   last_acc;
  exp_t sb[$];
  logic [TAG_W-1:0] got_tags[$];

  cplx_butterfly_pipe_if #(.I(I), .F(F), .TAG_W(TAG_W)) bus ();

  cplx_butterfly_pipe #(.I(I), .F(F), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint s16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Narrow an exact integer to a W-bit signed component.
  function automatic longint fit(input longint v);
    longint lim;
    longint r;
    lim = 64'sd1 <<< (W - 1);
`ifdef CPLX_BUTTERFLY_SAT_EN
    if (v > lim - 64'sd1) r = lim - 64'sd1;
    else if (v < -lim) r = -lim;
    else r = v;
`else
    r = v & ((64'sd1 <<< W) - 64'sd1);
    if (r >= lim) r = r - (64'sd1 <<< W);
`endif
    return r;
  endfunction

  function automatic exp_t model(input longint ar, input longint ai, input longint br,
                                 input longint bi, input longint wr, input longint wi,
                                 input int sc, input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint tr;
    longint ti;
    tr = fit((wr * br - wi * bi) >>> F);
    ti = fit((wr * bi + wi * br) >>> F);
    e.x.re = W'(fit((ar + tr) >>> sc));
    e.x.im = W'(fit((ai + ti) >>> sc));
    e.y.re = W'(fit((ar - tr) >>> sc));
    e.y.im = W'(fit((ai - ti) >>> sc));
    e.tag  = tag;
    return e;
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h4000;
      3: return 16'hC000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input bit v, input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi,
                       input logic [15:0] wr, input logic [15:0] wi,
                       input bit s, input logic [TAG_W-1:0] t);
    bus.in_valid = v;
    bus.a_re = ar; bus.a_im = ai;
    bus.b_re = br; bus.b_im = bi;
    bus.w_re = wr; bus.w_im = wi;
    bus.sc = s;
    bus.in_tag = t;
  endtask

  task automatic rand_txn(input bit v, input logic [TAG_W-1:0] t);
    drive(v, rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op(),
          1'($urandom_range(0, 1)), t);
  endtask

  // One clock: settle, score the handshakes about to happen, cross the edge.
  task automatic cycle();
    bit   acc;
    bit   cons;
    exp_t e;
    #2;
    acc  = bus.in_valid && bus.in_ready && !rst;
    cons = bus.out_valid && bus.out_ready && !rst;
    if (rst) begin
      sb.delete();
    end else begin
      if (cons) begin
        got_tags.push_back(bus.out_tag);
        if (sb.size() == 0) begin
          check_val("stale_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("x_re", s16(bus.x_re), s16(e.x.re));
          check_val("x_im", s16(bus.x_im), s16(e.x.im));
          check_val("y_re", s16(bus.y_re), s16(e.y.re));
          check_val("y_im", s16(bus.y_im), s16(e.y.im));
          check_val("tag", longint'(bus.out_tag), longint'(e.tag));
        end
      end
      if (acc) begin
        sb.push_back(model(s16(bus.a_re), s16(bus.a_im), s16(bus.b_re), s16(bus.b_im),
                           s16(bus.w_re), s16(bus.w_im), int'(bus.sc), bus.in_tag));
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  // Single transaction with known answer and exact 3-cycle latency.
  task automatic directed(input string name, input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi,
                          input logic [15:0] wr, input logic [15:0] wi, input bit s,
                          input logic [TAG_W-1:0] t,
                          input logic [15:0] exr, input logic [15:0] exi,
                          input logic [15:0] eyr, input logic [15:0] eyi);
    bus.out_ready = 1'b1;
    drive(1'b1, ar, ai, br, bi, wr, wi, s, t);
    cycle();
    check_val({name, "_acc"}, longint'(last_acc), 64'd1);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 10'h0);
    check_val({name, "_ov1"}, longint'(bus.out_valid), 64'd0);
    cycle();
    check_val({name, "_ov2"}, longint'(bus.out_valid), 64'd0);
    cycle();
    check_val({name, "_ov3"}, longint'(bus.out_valid), 64'd1);
    check_val({name, "_xre"}, s16(bus.x_re), s16(exr));
    check_val({name, "_xim"}, s16(bus.x_im), s16(exi));
    check_val({name, "_yre"}, s16(bus.y_re), s16(eyr));
    check_val({name, "_yim"}, s16(bus.y_im), s16(eyi));
    cycle();
  endtask

  initial begin
    int            nacc;
    int            k;
    logic [15:0]   hold_x;
    logic [TAG_W-1:0] hold_t;
    bit            seen_valid;

    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 10'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    check_val("rst_out_valid", longint'(bus.out_valid), 64'd0);
    check_val("rst_in_ready", longint'(bus.in_ready), 64'd1);
    check_val("rst_x_re", s16(bus.x_re), 64'd0);
    check_val("rst_y_im", s16(bus.y_im), 64'd0);
    check_val("rst_tag", longint'(bus.out_tag), 64'd0);

    directed("ident", 16'h2000, 16'h0, 16'h2000, 16'h0, 16'h4000, 16'h0, 1'b0, 10'd1,
             16'h4000, 16'h0, 16'h0, 16'h0);
    directed("scale", 16'h2000, 16'h0, 16'h2000, 16'h0, 16'h4000, 16'h0, 1'b1, 10'd2,
             16'h2000, 16'h0, 16'h0, 16'h0);
    directed("negj", 16'h2000, 16'h0, 16'h2000, 16'h0, 16'h0, 16'hC000, 1'b0, 10'd3,
             16'h2000, 16'hE000, 16'h2000, 16'h2000);
`ifdef CPLX_BUTTERFLY_SAT_EN
    directed("ovf", 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h4000, 16'h0, 1'b0, 10'd4,
             16'h7FFF, 16'h0, 16'h0, 16'h0);
`else
    directed("ovf", 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h4000, 16'h0, 1'b0, 10'd4,
             16'hFFFE, 16'h0, 16'h0, 16'h0);
`endif

    // Backpressure: five tagged transactions against a stalled sink.
    got_tags.delete();
    bus.out_ready = 1'b0;
    k = 1;
    nacc = 0;
    rand_txn(1'b1, 10'(k));
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (last_acc) begin
        nacc++;
        k++;
        if (k <= 5) rand_txn(1'b1, 10'(k));
        else bus.in_valid = 1'b0;
      end
    end
    check_val("bp_accepts", longint'(nacc), longint'(PIPE_DEPTH));
    check_val("bp_in_ready", longint'(bus.in_ready), 64'd0);
    hold_x = bus.x_re;
    hold_t = bus.out_tag;
    cycle();
    check_val("bp_hold_valid", longint'(bus.out_valid), 64'd1);
    check_val("bp_hold_x", s16(bus.x_re), s16(hold_x));
    check_val("bp_hold_tag", longint'(bus.out_tag), longint'(hold_t));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (last_acc) begin
        k++;
        if (k <= 5) rand_txn(1'b1, 10'(k));
        else bus.in_valid = 1'b0;
      end
    end
    check_val("bp_thru", longint'(got_tags.size()), 64'd5);
    bus.in_valid = 1'b0;
    repeat (3) cycle();
    check_val("bp_count", longint'(got_tags.size()), 64'd5);
    for (int i = 0; i < got_tags.size(); i++) begin
      check_val("bp_order", longint'(got_tags[i]), longint'(i + 1));
    end

    // Reset with three transactions in flight.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_txn(1'b1, 10'(100 + c));
      cycle();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("mrst_out_valid", longint'(bus.out_valid), 64'd0);
    check_val("mrst_in_ready", longint'(bus.in_ready), 64'd1);
    check_val("mrst_x_re", s16(bus.x_re), 64'd0);
    check_val("mrst_x_im", s16(bus.x_im), 64'd0);
    check_val("mrst_y_re", s16(bus.y_re), 64'd0);
    check_val("mrst_tag", longint'(bus.out_tag), 64'd0);
    bus.out_ready = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check_val("mrst_quiet", longint'(seen_valid), 64'd0);

    // Random traffic with random backpressure.
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(0, 99) < 70);
      if (!bus.in_valid || last_acc) rand_txn($urandom_range(0, 99) < 75, 10'($urandom));
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) cycle();
    check_val("drain_empty", longint'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
